bit_modulator: RTL and testbench

Downstream consumer of the ADC manager's parallel output: captures each byte announced by the ADC byte strobe into a small FIFO and serializes it MSB-first at a fixed bit period. Each bit keys a phase-accumulator carrier in OOK, BFSK or BPSK, or passes through as baseband. Outputs a 1-bit square carrier and an 8-bit triangle level for the DAC/PWM stage that follows.

---
 rtl/bit_modulator_pkg.sv | 27 ++
 rtl/bit_modulator_if.sv | 26 ++
 rtl/bit_modulator_fifo.sv | 54 +++++
 rtl/bit_modulator.sv | 190 +++++++++++++++++++
 tb/tb_bit_modulator.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/bit_modulator_pkg.sv
// Shared encodings for the bit modulator: carrier modes, FSM states, the
// idle DAC level and the number of bits sent per byte.
// Optional feature macro: MOD_FRAMING_EN (adds start/stop bits, 10 bits/byte).
package mod_pkg;

  typedef enum logic [1:0] {
    MOD_OOK      = 2'd0,
    MOD_BFSK     = 2'd1,
    MOD_BPSK     = 2'd2,
    MOD_BASEBAND = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  localparam logic [7:0] LEVEL_MID = 8'd128;

`ifdef MOD_FRAMING_EN
  localparam int FRAME_BITS = 10;
`else
  localparam int FRAME_BITS = 8;
`endif

endpackage

// File: rtl/bit_modulator_if.sv
// Byte-input / modulated-output bundle of the bit modulator.
// master = byte source and output consumer, slave = bit_modulator.
interface bit_modulator_if #(
  parameter int FIFO_DEPTH = 4
);
  logic                          new_byte;
  logic [7:0]                    byte_in;
  logic [1:0]                    mod_sel;
  logic                          enable;
  logic                          tx_active;
  logic                          bit_out;
  logic                          carrier_out;
  logic [7:0]                    level_out;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;
  logic                          overflow;

  modport master (
    output new_byte, byte_in, mod_sel, enable,
    input  tx_active, bit_out, carrier_out, level_out, fifo_count, overflow
  );

  modport slave (
    input  new_byte, byte_in, mod_sel, enable,
    output tx_active, bit_out, carrier_out, level_out, fifo_count, overflow
  );
endinterface

// File: rtl/bit_modulator_fifo.sv
// Small synchronous byte FIFO with first-word fall-through read port.
// A push while full is accepted only when a pop happens in the same cycle.
module byte_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [DATA_W-1:0]        i_din,
  output logic [DATA_W-1:0]        o_dout,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [AW:0]       r_count;
  logic              w_rd;
  logic              w_wr;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign w_rd    = i_pop & ~o_empty;
  assign w_wr    = i_push & (~o_full | w_rd);
  assign o_dout  = r_mem[r_rptr];
  assign o_count = r_count;

  // Storage array: data only, no reset needed.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= i_din;
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is 2^AW.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/bit_modulator.sv
// Captures strobed bytes into a FIFO and sends them MSB-first, one bit per
// BIT_PERIOD cycles, keying a phase-accumulator carrier (OOK/BFSK/BPSK) or
// passing the bit through as baseband. Emits a square carrier and an 8-bit
// triangle level.
// Optional feature macro: MOD_FRAMING_EN (start bit 0, data, stop bit 1).
module bit_modulator
  import mod_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int BIT_PERIOD = 1000,
  parameter int PHASE_W    = 16,
  parameter int F0_INC     = 655,
  parameter int F1_INC     = 1310
) (
  input  logic               clk,
  input  logic               rst,
  bit_modulator_if.slave     bus
);
  localparam int SW = FRAME_BITS;
  localparam int IW = $clog2(FRAME_BITS);
  localparam int CW = $clog2(BIT_PERIOD);
  localparam logic [CW-1:0]      CNT_LAST = CW'(BIT_PERIOD - 1);
  localparam logic [PHASE_W-1:0] INC0     = PHASE_W'(F0_INC);
  localparam logic [PHASE_W-1:0] INC1     = PHASE_W'(F1_INC);
  localparam logic [PHASE_W-1:0] HALF     = {1'b1, {(PHASE_W-1){1'b0}}};

  // Folds the upper phase bits into a symmetric triangle.
  function automatic logic [7:0] tri_level(input logic [PHASE_W-1:0] p);
    logic [7:0] t;
    t = p[PHASE_W-2 -: 8];
    return p[PHASE_W-1] ? ~t : t;
  endfunction

  logic                        r_new_byte_d;
  logic                        w_push;
  logic                        w_pop;
  logic                        w_full;
  logic                        w_empty;
  logic [7:0]                  w_head;
  logic [$clog2(FIFO_DEPTH):0] w_count;
  logic [SW-1:0]               w_frame;

  state_t                      r_state;
  mode_t                       r_mode;
  logic [SW-1:0]               r_shift;
  logic [IW-1:0]               r_bit_idx;
  logic [CW-1:0]               r_cnt;
  logic                        r_tx_active;
  logic                        r_bit_out;
  logic                        r_overflow;

  logic [PHASE_W-1:0]          r_phase;
  logic [PHASE_W-1:0]          w_inc;
  logic [PHASE_W-1:0]          w_peff;
  logic                        w_car_n;
  logic [7:0]                  w_lvl_n;
  logic                        r_carrier;
  logic [7:0]                  r_level;

  assign w_push = bus.new_byte & ~r_new_byte_d;
  assign w_pop  = (r_state == ST_LOAD);

`ifdef MOD_FRAMING_EN
  assign w_frame = {1'b0, w_head, 1'b1};
`else
  assign w_frame = w_head;
`endif

  byte_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (8)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (bus.byte_in),
    .o_dout  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Strobe edge detector and sticky drop flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_new_byte_d <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_new_byte_d <= bus.new_byte;
      if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  // Transmit FSM: fetch a byte, then hold each bit for BIT_PERIOD cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_mode      <= MOD_OOK;
      r_shift     <= '0;
      r_bit_idx   <= '0;
      r_cnt       <= '0;
      r_tx_active <= 1'b0;
      r_bit_out   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.enable && !w_empty) begin
            r_state     <= ST_LOAD;
            r_tx_active <= 1'b1;
          end
        end
        ST_LOAD: begin
          r_shift   <= w_frame;
          r_bit_out <= w_frame[SW-1];
          r_mode    <= mode_t'(bus.mod_sel);
          r_bit_idx <= IW'(SW - 1);
          r_cnt     <= CNT_LAST;
          r_state   <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else if (r_bit_idx == '0) begin
            // Last bit done: chain straight into the next byte if allowed.
            if (bus.enable && !w_empty) begin
              r_state <= ST_LOAD;
            end else begin
              r_state     <= ST_IDLE;
              r_tx_active <= 1'b0;
              r_bit_out   <= 1'b0;
            end
          end else begin
            r_shift   <= {r_shift[SW-2:0], 1'b0};
            r_bit_out <= r_shift[SW-2];
            r_bit_idx <= r_bit_idx - 1'b1;
            r_cnt     <= CNT_LAST;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Next carrier/level from the current phase, bit and latched mode.
  always_comb begin
    w_inc   = (r_mode == MOD_BFSK && r_bit_out) ? INC1 : INC0;
    w_peff  = r_phase + ((r_mode == MOD_BPSK && !r_bit_out) ? HALF : '0);
    w_car_n = w_peff[PHASE_W-1];
    w_lvl_n = tri_level(w_peff);
    case (r_mode)
      MOD_OOK: begin
        if (!r_bit_out) begin
          w_car_n = 1'b0;
          w_lvl_n = LEVEL_MID;
        end
      end
      MOD_BASEBAND: begin
        w_car_n = r_bit_out;
        w_lvl_n = r_bit_out ? 8'hFF : 8'h00;
      end
      default: ;
    endcase
  end

  // Phase accumulator and registered outputs, one cycle behind the phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_phase   <= '0;
      r_carrier <= 1'b0;
      r_level   <= LEVEL_MID;
    end else if (r_state == ST_SHIFT) begin
      r_phase   <= r_phase + w_inc;
      r_carrier <= w_car_n;
      r_level   <= w_lvl_n;
    end else begin
      r_phase   <= '0;
      r_carrier <= 1'b0;
      r_level   <= LEVEL_MID;
    end
  end

  assign bus.tx_active   = r_tx_active;
  assign bus.bit_out     = r_bit_out;
  assign bus.carrier_out = r_carrier;
  assign bus.level_out   = r_level;
  assign bus.fifo_count  = w_count;
  assign bus.overflow    = r_overflow;

endmodule

// File: tb/tb_bit_modulator.sv
// Directed bench for bit_modulator with a short bit period and round-number
// phase increments so carrier/triangle values are easy to derive by hand.
module tb_bit_modulator;
  import mod_pkg::*;

  localparam int BP    = 4;
  localparam int DEPTH = 4;
  localparam int PW    = 16;
  localparam int F0    = 4096;
  localparam int F1    = 8192;
`ifdef MOD_FRAMING_EN
  localparam int NB = 10;
`else
  localparam int NB = 8;
`endif

  typedef struct {
    logic [7:0] din;
    logic [1:0] mode;
    logic [7:0] exp_bits;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  bit_modulator_if #(.FIFO_DEPTH(DEPTH)) bus ();

  bit_modulator #(
    .FIFO_DEPTH (DEPTH),
    .BIT_PERIOD (BP),
    .PHASE_W    (PW),
    .F0_INC     (F0),
    .F1_INC     (F1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Bit i (0 = first sent) of the frame for byte b.
  function automatic logic frame_bit(input logic [7:0] b, input int i);
`ifdef MOD_FRAMING_EN
    if (i == 0) return 1'b0;
    if (i == NB - 1) return 1'b1;
    return b[8 - i];
`else
    return b[7 - i];
`endif
  endfunction

  function automatic logic [PW-1:0] inc_of(input logic b, input logic [1:0] mode);
    return (mode == 2'd1 && b) ? PW'(F1) : PW'(F0);
  endfunction

  // {carrier, level} expected for a phase/bit/mode.
  function automatic logic [8:0] mod_exp(input logic [PW-1:0] ph, input logic b,
                                         input logic [1:0] mode);
    logic [PW-1:0] p;
    logic [7:0]    t;
    if (mode == 2'd3) return {b, (b ? 8'hFF : 8'h00)};
    if (mode == 2'd0 && !b) return {1'b0, 8'd128};
    p = ph;
    if (mode == 2'd2 && !b) p = p + 16'h8000;
    t = p[14:7];
    return {p[15], (p[15] ? ~t : t)};
  endfunction

  task automatic run_byte(input vec_t v);
    logic [PW-1:0] ph;
    logic          pb;
    logic          eb;
    logic [8:0]    e;
    @(negedge clk);
    bus.byte_in  = v.din;
    bus.mod_sel  = v.mode;
    bus.new_byte = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("count_after_write", 32'(bus.fifo_count), 1);
    chk("tx_before_load", 32'(bus.tx_active), 0);
    @(posedge clk);
    @(negedge clk);
    chk("tx_in_load", 32'(bus.tx_active), 1);
    @(posedge clk);
    ph = '0;
    pb = 1'b0;
    for (int k = 0; k <= NB * BP; k++) begin
      @(negedge clk);
      if (k == 0) bus.mod_sel = ~v.mode;
      if (k >= 1) begin
        e = mod_exp(ph, pb, v.mode);
        chk("carrier", 32'(bus.carrier_out), 32'(e[8]));
        chk("level", 32'(bus.level_out), 32'(e[7:0]));
        ph = ph + inc_of(pb, v.mode);
      end
      if (k < NB * BP) begin
        eb = frame_bit(v.exp_bits, k / BP);
        chk("bit_out", 32'(bus.bit_out), 32'(eb));
        chk("tx_active", 32'(bus.tx_active), 1);
        pb = eb;
        @(posedge clk);
      end else begin
        chk("tx_end", 32'(bus.tx_active), 0);
        chk("bit_end", 32'(bus.bit_out), 0);
        chk("count_end", 32'(bus.fifo_count), 0);
      end
    end
    bus.mod_sel  = v.mode;
    bus.new_byte = 1'b0;
    repeat (3) @(negedge clk);
    chk("single_write_idle", 32'(bus.tx_active), 0);
    chk("level_idle", 32'(bus.level_out), 128);
  endtask

  task automatic strobe(input logic [7:0] b);
    @(negedge clk);
    bus.byte_in  = b;
    bus.new_byte = 1'b1;
    @(negedge clk);
    bus.new_byte = 1'b0;
  endtask

  vec_t vecs[6];
  logic [7:0] ob[5];

  initial begin
    bus.new_byte = 1'b0;
    bus.byte_in  = 8'h00;
    bus.mod_sel  = 2'd0;
    bus.enable   = 1'b0;
    rst          = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx", 32'(bus.tx_active), 0);
    chk("rst_bit", 32'(bus.bit_out), 0);
    chk("rst_carrier", 32'(bus.carrier_out), 0);
    chk("rst_level", 32'(bus.level_out), 128);
    chk("rst_count", 32'(bus.fifo_count), 0);
    chk("rst_overflow", 32'(bus.overflow), 0);
    rst        = 1'b1;
    bus.enable = 1'b1;

    // Single bytes, strobe held high across the whole transfer.
    vecs[0] = '{din: 8'hA5, mode: 2'd3, exp_bits: 8'b1010_0101};
    vecs[1] = '{din: 8'h00, mode: 2'd3, exp_bits: 8'b0000_0000};
    vecs[2] = '{din: 8'hF0, mode: 2'd1, exp_bits: 8'b1111_0000};
    vecs[3] = '{din: 8'h80, mode: 2'd2, exp_bits: 8'b1000_0000};
    vecs[4] = '{din: 8'hC3, mode: 2'd0, exp_bits: 8'b1100_0011};
    vecs[5] = '{din: 8'h3C, mode: 2'd2, exp_bits: 8'b0011_1100};
    for (int i = 0; i < 6; i++) run_byte(vecs[i]);

    // Fill while disabled, overflow on the fifth byte, then drain back-to-back.
    ob[0] = 8'h12; ob[1] = 8'h34; ob[2] = 8'h56; ob[3] = 8'h78; ob[4] = 8'h9A;
    @(negedge clk);
    bus.enable  = 1'b0;
    bus.mod_sel = 2'd3;
    for (int i = 0; i < 5; i++) strobe(ob[i]);
    @(negedge clk);
    chk("ovf_count", 32'(bus.fifo_count), 4);
    chk("ovf_flag", 32'(bus.overflow), 1);
    chk("ovf_tx_idle", 32'(bus.tx_active), 0);
    bus.enable = 1'b1;
    @(posedge clk);
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      chk("b2b_load_tx", 32'(bus.tx_active), 1);
      chk("b2b_load_count", 32'(bus.fifo_count), 32'(4 - b));
      if (b > 0) chk("b2b_gap_hold", 32'(bus.bit_out), 32'(frame_bit(ob[b-1], NB - 1)));
      @(posedge clk);
      for (int k = 0; k < NB * BP; k++) begin
        @(negedge clk);
        chk("b2b_bit", 32'(bus.bit_out), 32'(frame_bit(ob[b], k / BP)));
        @(posedge clk);
      end
    end
    @(negedge clk);
    chk("b2b_done_tx", 32'(bus.tx_active), 0);
    chk("b2b_fifth_lost", 32'(bus.fifo_count), 0);
    chk("ovf_sticky", 32'(bus.overflow), 1);

    // Asynchronous reset in the middle of a bit with bytes still queued.
    bus.enable = 1'b0;
    for (int i = 0; i < 3; i++) strobe(8'hFF);
    @(negedge clk);
    bus.enable = 1'b1;
    repeat (7) @(posedge clk);
    #2;
    chk("pre_rst_bit", 32'(bus.bit_out), 1);
    chk("pre_rst_count", 32'(bus.fifo_count), 2);
    rst = 1'b0;
    #1;
    chk("arst_tx", 32'(bus.tx_active), 0);
    chk("arst_bit", 32'(bus.bit_out), 0);
    chk("arst_carrier", 32'(bus.carrier_out), 0);
    chk("arst_level", 32'(bus.level_out), 128);
    chk("arst_count", 32'(bus.fifo_count), 0);
    chk("arst_overflow", 32'(bus.overflow), 0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("post_rst_quiet", 32'(bus.tx_active), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
